// File: rtl/beam_thresh_sequencer.sv
// beam_thresh_sequencer
// Holds a shadow copy of every beam's {B,A} 18-bit threshold pair and, on
// request, shifts the whole store into the beamformer threshold cascade
// (highest beam first), then issues one commit strobe for the selected halves.
// Optional feature macro: THRESH_READBACK_EN adds a registered host readback
// port; when it is undefined rd_data_o is tied to zero.
module beam_thresh_sequencer #(
   parameter int          NBEAMS         = 2,
   parameter logic [17:0] THRESH_DEFAULT = 18'h3FFFF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        thr_wr_i,
   input  logic [$clog2(NBEAMS)-1:0]   thr_addr_i,
   input  logic [35:0]                 thr_data_i,
   input  logic                        start_i,
   input  logic [1:0]                  mask_i,
   input  logic [$clog2(NBEAMS)-1:0]   rd_addr_i,
   output logic [35:0]                 rd_data_o,
   output logic [35:0]                 thresh_o,
   output logic [1:0]                  thresh_wr_o,
   output logic [1:0]                  thresh_update_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        wr_err_o
);

   localparam int            AW       = $clog2(NBEAMS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NBEAMS - 1);
   localparam logic [AW:0]   NB_W     = (AW + 1)'(NBEAMS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_UPDATE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    mask_q, mask_d;

   logic [35:0]   shadow_q [NBEAMS];

   logic          in_idle, wr_addr_ok, wr_ok, wr_drop, start_ok;
   logic [35:0]   load_data;
   logic [35:0]   thresh_d;
   logic [1:0]    thresh_wr_d, thresh_update_d;
   logic          busy_d, done_d, wr_err_d;
   logic          wr_err_q;

   // Write acceptance, error flag and next cascade word
   always_comb begin
      in_idle    = (state_q == ST_IDLE);
      wr_addr_ok = ({1'b0, thr_addr_i} < NB_W);
      wr_ok      = thr_wr_i && in_idle && wr_addr_ok;
      wr_drop    = thr_wr_i && !wr_ok;
      start_ok   = start_i && in_idle;
      // an error in the start cycle wins over the clear
      wr_err_d   = wr_drop | (wr_err_q & ~start_ok);
      // forward a same-cycle write so it is part of the sequence it starts with
      if (wr_ok && (thr_addr_i == idx_d))
         load_data = thr_data_i;
      else
         load_data = shadow_q[idx_d];
   end

   // Shadow threshold store, one register per beam
   for (genvar gi = 0; gi < NBEAMS; gi++) begin : g_shadow
      // Host write into this beam's entry
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i)
            shadow_q[gi] <= {THRESH_DEFAULT, THRESH_DEFAULT};
         else if (wr_ok && (thr_addr_i == AW'(gi)))
            shadow_q[gi] <= thr_data_i;
      end
   end

   // Next-state logic and output values for the coming state
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (mask_i != 2'b00) begin
                  state_d = ST_LOAD;
                  idx_d   = LAST_IDX;
                  mask_d  = mask_i;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            if (idx_q == '0)
               state_d = ST_UPDATE;
            else
               idx_d = idx_q - 1'b1;
         end
         ST_UPDATE: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      thresh_d        = (state_d == ST_LOAD)   ? load_data : 36'd0;
      thresh_wr_d     = (state_d == ST_LOAD)   ? mask_d    : 2'b00;
      thresh_update_d = (state_d == ST_UPDATE) ? mask_d    : 2'b00;
      busy_d          = (state_d != ST_IDLE);
      done_d          = (state_d == ST_DONE);
   end

   // State register plus registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         idx_q           <= '0;
         mask_q          <= 2'b00;
         thresh_o        <= 36'd0;
         thresh_wr_o     <= 2'b00;
         thresh_update_o <= 2'b00;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         wr_err_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         mask_q          <= mask_d;
         thresh_o        <= thresh_d;
         thresh_wr_o     <= thresh_wr_d;
         thresh_update_o <= thresh_update_d;
         busy_o          <= busy_d;
         done_o          <= done_d;
         wr_err_q        <= wr_err_d;
      end
   end

   assign wr_err_o = wr_err_q;

`ifdef THRESH_READBACK_EN
   logic        rd_addr_ok;
   logic [35:0] rd_data_q;

   // Range check for the readback index
   always_comb begin
      rd_addr_ok = ({1'b0, rd_addr_i} < NB_W);
   end

   // Registered readback of the shadow store
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         rd_data_q <= 36'd0;
      else
         rd_data_q <= rd_addr_ok ? shadow_q[rd_addr_i] : 36'd0;
   end

   assign rd_data_o = rd_data_q;
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^rd_addr_i;
   assign rd_data_o      = 36'd0;
`endif

endmodule

// File: tb/tb_beam_thresh_sequencer.sv
// Self-checking bench for beam_thresh_sequencer (NBEAMS = 4).
// A sequence-level reference model predicts every output each cycle; directed
// scenarios add literal expectations, then a randomized phase runs.
module tb_beam_thresh_sequencer;

   localparam int          NB  = 4;
   localparam logic [17:0] DEF = 18'h3FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        thr_wr;
   logic [1:0]  thr_addr;
   logic [35:0] thr_data;
   logic        start;
   logic [1:0]  mask;
   logic [1:0]  rd_addr;
   logic [35:0] rd_data;
   logic [35:0] thresh;
   logic [1:0]  thresh_wr;
   logic [1:0]  thresh_update;
   logic        busy;
   logic        done;
   logic        wr_err;

   int total = 0;
   int bad   = 0;

   beam_thresh_sequencer #(
      .NBEAMS(NB),
      .THRESH_DEFAULT(DEF)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .thr_wr_i        (thr_wr),
      .thr_addr_i      (thr_addr),
      .thr_data_i      (thr_data),
      .start_i         (start),
      .mask_i          (mask),
      .rd_addr_i       (rd_addr),
      .rd_data_o       (rd_data),
      .thresh_o        (thresh),
      .thresh_wr_o     (thresh_wr),
      .thresh_update_o (thresh_update),
      .busy_o          (busy),
      .done_o          (done),
      .wr_err_o        (wr_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [35:0] sh   [NB];
   logic [35:0] snap [NB];
   int          s_edge;
   logic [1:0]  s_mask;
   int          ecnt;
   logic        m_err;
   logic [35:0] m_rd;
   logic [35:0] e_thresh;
   logic [1:0]  e_wr, e_upd;
   logic        e_busy, e_done;

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) sh[i] = {DEF, DEF};
      s_edge = -1; s_mask = 2'b00; ecnt = 0; m_err = 1'b0; m_rd = '0;
      e_thresh = '0; e_wr = '0; e_upd = '0; e_busy = 1'b0; e_done = 1'b0;
   endtask

   // a sequence accepted at edge s keeps the block busy for the periods after
   // edges s .. s+len-1 (len = NB+2 for a load, 1 for an empty mask)
   function automatic bit active_at(input int x);
      int len;
      if (s_edge < 0 || x < s_edge) return 1'b0;
      len = (s_mask != 2'b00) ? NB + 2 : 1;
      return (x - s_edge) < len;
   endfunction

   task automatic model_edge();
      bit busy_prev, err;
      int k;
      busy_prev = active_at(ecnt - 1);
`ifdef THRESH_READBACK_EN
      m_rd = (int'(rd_addr) < NB) ? sh[rd_addr] : 36'd0;
`else
      m_rd = 36'd0;
`endif
      err = 1'b0;
      if (thr_wr) begin
         if (busy_prev || int'(thr_addr) >= NB) err = 1'b1;
         else sh[thr_addr] = thr_data;
      end
      if (start && !busy_prev) begin
         s_edge = ecnt;
         s_mask = mask;
         for (int i = 0; i < NB; i++) snap[i] = sh[i];
         m_err = err;
      end else if (err) begin
         m_err = 1'b1;
      end
      e_thresh = '0; e_wr = '0; e_upd = '0; e_busy = 1'b0; e_done = 1'b0;
      if (active_at(ecnt)) begin
         k = ecnt - s_edge;
         e_busy = 1'b1;
         if (s_mask == 2'b00) e_done = 1'b1;
         else if (k < NB) begin e_wr = s_mask; e_thresh = snap[NB - 1 - k]; end
         else if (k == NB) e_upd = s_mask;
         else e_done = 1'b1;
      end
      ecnt++;
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("thresh_o", thresh, e_thresh);
         chk("thresh_wr_o", {34'd0, thresh_wr}, {34'd0, e_wr});
         chk("thresh_update_o", {34'd0, thresh_update}, {34'd0, e_upd});
         chk("busy_o", {35'd0, busy}, {35'd0, e_busy});
         chk("done_o", {35'd0, done}, {35'd0, e_done});
         chk("wr_err_o", {35'd0, wr_err}, {35'd0, m_err});
         chk("rd_data_o", rd_data, m_rd);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      thr_wr = 1'b0; thr_addr = '0; thr_data = '0; start = 1'b0; mask = '0; rd_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " thresh_o"}, thresh, 36'd0);
      chk({tag, " thresh_wr_o"}, {34'd0, thresh_wr}, 36'd0);
      chk({tag, " thresh_update_o"}, {34'd0, thresh_update}, 36'd0);
      chk({tag, " busy_o"}, {35'd0, busy}, 36'd0);
      chk({tag, " done_o"}, {35'd0, done}, 36'd0);
      chk({tag, " wr_err_o"}, {35'd0, wr_err}, 36'd0);
      chk({tag, " rd_data_o"}, rd_data, 36'd0);
   endtask

   // asynchronous reset in mid-cycle, outputs checked before any clock edge
   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      #1 check_all_zero(tag);
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   int cnt;
   logic [35:0] exp_rb;

   initial begin
      idle_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      model_reset();

      // default thresholds streamed out with both halves selected
      start = 1'b1; mask = 2'b11; step(); start = 1'b0; mask = 2'b00;
      for (int c = 1; c <= 4; c++) begin
         chk("dflt wr", {34'd0, thresh_wr}, 36'd3);
         chk("dflt data", thresh, 36'hFFFFFFFFF);
         step();
      end
      chk("dflt upd", {34'd0, thresh_update}, 36'd3);
      chk("dflt wr off", {34'd0, thresh_wr}, 36'd0);
      step();
      chk("dflt done", {35'd0, done}, 36'd1);
      step();
      chk("dflt idle", {35'd0, busy}, 36'd0);
      $display("scenario default-load complete");

      // programmed values come out highest beam first, A half only
      for (int b = 0; b < NB; b++) begin
         thr_wr = 1'b1; thr_addr = 2'(b); thr_data = 36'(b + 1); step();
      end
      thr_wr = 1'b0;
      start = 1'b1; mask = 2'b01; step(); start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk("order data", thresh, 36'(5 - c));
         chk("order wr", {34'd0, thresh_wr}, 36'd1);
         step();
      end
      chk("order upd", {34'd0, thresh_update}, 36'd1);
      step(); step();
      $display("scenario ordered-load complete");

      // write in the start cycle is part of the sequence
      thr_wr = 1'b1; thr_addr = 2'd1; thr_data = 36'h00ABC0DEF;
      start = 1'b1; mask = 2'b11; step(); idle_inputs();
      step(); step();
      chk("samecycle data", thresh, 36'h00ABC0DEF);
      repeat (4) step();
      $display("scenario same-cycle-write complete");

      // write and restart while busy: dropped / ignored
      start = 1'b1; mask = 2'b11; step(); start = 1'b0;
      step();
      thr_wr = 1'b1; thr_addr = 2'd2; thr_data = 36'h555555555; step(); thr_wr = 1'b0;
      start = 1'b1; mask = 2'b11; step(); start = 1'b0;
      chk("busy wr_err", {35'd0, wr_err}, 36'd1);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (thresh_update != 2'b00) cnt++;
         step();
      end
      chk("busy one update", 36'(cnt), 36'd1);
      start = 1'b1; mask = 2'b11; step(); start = 1'b0;
      chk("err cleared", {35'd0, wr_err}, 36'd0);
      step();
      chk("shadow2 kept", thresh, 36'd3);
      repeat (5) step();
      $display("scenario busy-drop complete");

      // empty mask: straight to done
      start = 1'b1; mask = 2'b00; step(); start = 1'b0;
      chk("nomask done", {35'd0, done}, 36'd1);
      chk("nomask wr", {34'd0, thresh_wr}, 36'd0);
      chk("nomask upd", {34'd0, thresh_update}, 36'd0);
      chk("nomask busy", {35'd0, busy}, 36'd1);
      step();
      chk("nomask done off", {35'd0, done}, 36'd0);
      chk("nomask idle", {35'd0, busy}, 36'd0);
      $display("scenario empty-mask complete");

      // reset during LOAD
      start = 1'b1; mask = 2'b11; step(); start = 1'b0;
      step();
      do_reset("midload");
      rd_addr = 2'd1;
      cnt = 0;
      for (int c = 0; c < 7; c++) begin
         step();
         if (thresh_update != 2'b00) cnt++;
      end
      chk("midload no update", 36'(cnt), 36'd0);
`ifdef THRESH_READBACK_EN
      exp_rb = {DEF, DEF};
`else
      exp_rb = 36'd0;
`endif
      chk("readback beam1", rd_data, exp_rb);
      $display("scenario reset-midload complete");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            do_reset("random");
         end else begin
            thr_wr   = ($urandom_range(0, 3) == 0);
            thr_addr = 2'($urandom);
            thr_data = {4'($urandom), $urandom};
            start    = ($urandom_range(0, 7) == 0);
            mask     = 2'($urandom);
            rd_addr  = 2'($urandom);
            step();
         end
      end
      idle_inputs();
      repeat (NB + 4) step();
      $display("scenario random complete");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beam_thresh_sequencer.md
BEAM_THRESH_SEQUENCER -- requirements
Module: beam_thresh_sequencer

Interface
REQ-001 Parameter NBEAMS, default 2: number of beams whose thresholds sit on the threshold cascade; even, 2..48.
REQ-002 Parameter THRESH_DEFAULT, default 18'h3FFFF: reset value of every 18-bit shadow threshold, in both the A and B halves.
REQ-003 clk_i  input  1: sole clock.
REQ-004 rst_i  input  1: asynchronous, active-high reset.
REQ-005 thr_wr_i  input  1: host write strobe into the shadow threshold store.
REQ-006 thr_addr_i  input  $clog2(NBEAMS): beam index for the write.
REQ-007 thr_data_i  input  36: {B[17:0], A[17:0]} threshold pair for that beam.
REQ-008 start_i  input  1: single-cycle request to load the whole shadow store into the cascade.
REQ-009 mask_i  input  2: threshold halves to load; bit0 = A, bit1 = B; sampled with start_i.
REQ-010 rd_addr_i  input  $clog2(NBEAMS): readback beam index.
REQ-011 rd_data_o  output  36: readback of the shadow pair.
REQ-012 thresh_o  output  36: cascade threshold data, driven to the beamformer thresh_i.
REQ-013 thresh_wr_o  output  2: cascade shift strobes, driven to thresh_wr_i.
REQ-014 thresh_update_o  output  2: cascade commit strobes, driven to thresh_update_i.
REQ-015 busy_o  output  1: sequence in progress.
REQ-016 done_o  output  1: one-cycle pulse when a sequence completes.
REQ-017 wr_err_o  output  1: sticky flag, set when a host write is dropped.

Function
REQ-018 Shadow store: NBEAMS x 36-bit registers; thr_wr_i in IDLE writes thr_data_i to entry thr_addr_i on the next edge.
REQ-019 Out-of-range thr_addr_i (>= NBEAMS): write dropped, wr_err_o set.
REQ-020 FSM states: IDLE, LOAD, UPDATE, DONE.
REQ-021 IDLE -> LOAD on start_i with mask_i != 0; mask latched, beam index counter loaded with NBEAMS-1.
REQ-022 IDLE -> DONE on start_i with mask_i == 0; no strobes are issued.
REQ-023 LOAD, one beam per cycle:
  - thresh_o = shadow[idx]; thresh_wr_o = latched mask.
  - idx decrements each cycle; the highest beam goes first, beam 0 last.
  - Exactly NBEAMS consecutive strobe cycles.
REQ-024 LOAD -> UPDATE after the idx == 0 cycle.
REQ-025 UPDATE: one cycle with thresh_update_o = latched mask and thresh_wr_o = 0; then -> DONE.
REQ-026 DONE: done_o = 1 for one cycle; then -> IDLE.
REQ-027 busy_o = 1 in LOAD, UPDATE and DONE.
REQ-028 Outside LOAD, thresh_o = 0 and thresh_wr_o = 0; outside UPDATE, thresh_update_o = 0.
REQ-029 Timing, with start_i sampled at edge 0:
  - thresh_wr_o high in cycles 1..NBEAMS.
  - thresh_update_o high in cycle NBEAMS+1.
  - done_o high in cycle NBEAMS+2.
  - IDLE from cycle NBEAMS+3.
REQ-030 start_i while busy_o = 1: ignored; no queuing.
REQ-031 thr_wr_i while busy_o = 1: dropped, shadow unchanged, wr_err_o set.
REQ-032 thr_wr_i and start_i in the same IDLE cycle: the write lands first and is included in the sequence.
REQ-033 wr_err_o clears on any accepted start_i, unless an error event occurs in that same cycle, in which case it stays set.
REQ-034 All outputs are registered; none are combinational from inputs.

Reset
REQ-035 rst_i asserted, at any time including mid-sequence:
  - FSM -> IDLE; idx and latched mask -> 0.
  - Every shadow entry -> {THRESH_DEFAULT, THRESH_DEFAULT}.
  - thresh_o, thresh_wr_o, thresh_update_o, busy_o, done_o, wr_err_o, rd_data_o -> 0, asynchronously.
REQ-036 A sequence interrupted by reset emits no thresh_update_o; a new start_i is required after release.

Configuration
REQ-037 Macro THRESH_READBACK_EN defined: rd_data_o = shadow[rd_addr_i], registered, latency 1 cycle; out-of-range rd_addr_i returns 0.
REQ-038 Macro THRESH_READBACK_EN undefined: rd_data_o tied to 0; the readback mux is not built; all other behaviour is identical.

Verification
REQ-039 Reset release with NBEAMS=4, then start_i with mask=2'b11 -> four thresh_wr_o=2'b11 cycles, each with thresh_o=36'hFFFFFFFFF, then one thresh_update_o=2'b11 cycle, then done_o at cycle 6.
REQ-040 Write beams 0..3 = 36'h000000001..36'h000000004, start_i with mask=2'b01 -> thresh_o sequence 4,3,2,1 with thresh_wr_o=2'b01, then thresh_update_o=2'b01 at cycle 5.
REQ-041 thr_wr_i to beam 2 at cycle 2 of a sequence, plus a second start_i at cycle 3 -> shadow[2] unchanged, wr_err_o=1, only one update pulse; the next start_i clears wr_err_o.
REQ-042 start_i with mask=2'b00 -> no thresh_wr_o or thresh_update_o; done_o at cycle 1.
REQ-043 rst_i asserted at cycle 2 of LOAD -> all outputs 0 immediately, no update pulse; readback of beam 1 returns {THRESH_DEFAULT, THRESH_DEFAULT} when THRESH_READBACK_EN is defined, 0 when it is not.
REQ-044 thr_wr_i to beam 1 with data 36'h00ABC0DEF in the same IDLE cycle as start_i (mask=2'b11) -> the third strobe cycle carries thresh_o=36'h00ABC0DEF.
